// File: rtl/md_ctrl_if.sv
// Start/result handshake between the mul/div sequencer and the multdiv unit.
// The sequencer side is master; the multdiv unit side is slave.
interface md_ctrl_if;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic        md_ready;
    logic [31:0] md_result;
    logic        md_exception;

    modport master (
        output ctrl_mult, ctrl_div,
        input  md_ready, md_result, md_exception
    );

    modport slave (
        input  ctrl_mult, ctrl_div,
        output md_ready, md_result, md_exception
    );
endinterface

// File: rtl/md_ctrl.sv
// Multi-cycle mul/div sequencer: issues the start pulse, stalls the front end while the
// multdiv unit runs, then bubbles XM and presents one writeback request (rstatus on exception).
module md_ctrl #(
    parameter int MAX_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dx_ir,
    input  logic        flush,
    md_ctrl_if.master   md,
    output logic        stall,
    output logic        dx_bubble,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        timeout_err
);
    localparam int CW = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic            op_div;
    logic [4:0]      rd_q;
    logic            ctrl_mult, ctrl_div;

    logic is_md, dx_div, issue, timeout_hit, capture, exc;

    assign is_md  = (dx_ir[31:27] == 5'b00000) &&
                    ((dx_ir[6:2] == 5'b00110) || (dx_ir[6:2] == 5'b00111));
    assign dx_div = dx_ir[2];

    // The issue-cycle outputs are combinational from dx_ir, so they are also held low
    // while reset is asserted to keep every output at 0 during reset.
    assign issue = (state == IDLE) && is_md && !flush && reset;

    // cnt holds j-1 in the j-th cycle after issue, so this lands DONE at issue+MAX_CYCLES.
    assign timeout_hit = (state == BUSY) && !flush && !md.md_ready &&
                         (cnt == CW'(MAX_CYCLES - 2));
    assign capture     = (state == BUSY) && !flush && (md.md_ready || timeout_hit);
    assign exc         = timeout_hit || md.md_exception;

    assign md.ctrl_mult = ctrl_mult;
    assign md.ctrl_div  = ctrl_div;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        dx_bubble  = 1'b0;
        wb_valid   = 1'b0;
        ctrl_mult  = 1'b0;
        ctrl_div   = 1'b0;
        case (state)
            IDLE: begin
                if (issue) begin
                    ctrl_mult  = !dx_div;
                    ctrl_div   = dx_div;
                    stall      = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (flush)
                    state_next = IDLE;
                else if (md.md_ready || timeout_hit)
                    state_next = DONE;
            end
            DONE: begin
                dx_bubble  = 1'b1;
                wb_valid   = !flush;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            op_div      <= 1'b0;
            rd_q        <= 5'd0;
            wb_rd       <= 5'd0;
            wb_data     <= 32'd0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_next;
            if (issue) begin
                cnt    <= '0;
                op_div <= dx_div;
                rd_q   <= dx_ir[26:22];
            end else if (state == BUSY) begin
                cnt <= cnt + 1'b1;
            end
            // Writeback fields are formed on entry to DONE and then held until the next op.
            if (capture) begin
                if (exc) begin
                    wb_rd   <= 5'd30;
                    wb_data <= op_div ? 32'd2 : 32'd1;
                end else begin
                    wb_rd   <= rd_q;
                    wb_data <= md.md_result;
                end
            end
            if (timeout_hit)
                timeout_err <= 1'b1;
        end
    end
endmodule

// File: doc/md_ctrl.md
# md_ctrl

Multi-cycle multiply/divide sequencer for the 5-stage pipeline. Decodes the instruction in the DX latch, issues a one-cycle start pulse to the multdiv unit, and stalls fetch/decode/DX while the unit runs. It captures the result or exception, bubbles the original instruction out of XM, and presents a single-cycle writeback request that the writeback mux merges into the regfile port. It sits beside the bypass/hazard logic and owns the only path by which mul/div results commit.

## Interface
- MAX_CYCLES, default 64: cycles allowed in BUSY before a forced timeout; counter width is clog2(MAX_CYCLES+1).
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 forces IDLE and clears all registers and outputs
- dx_ir  in  32  instruction in the DX latch
- flush  in  1  squash of the DX instruction (taken branch/jump resolved downstream)
- md_ready  in  1  multdiv data_resultRDY
- md_result  in  32  multdiv result
- md_exception  in  1  multdiv overflow / divide-by-zero
- ctrl_mult  out  1  one-cycle multiply start pulse
- ctrl_div  out  1  one-cycle divide start pulse
- stall  out  1  freezes PC, FD and DX latches
- dx_bubble  out  1  inserts a nop into XM in place of the DX instruction
- wb_valid  out  1  one-cycle writeback request
- wb_rd  out  5  writeback register
- wb_data  out  32  writeback value
- timeout_err  out  1  sticky; set on any timeout and cleared only by reset

## Operation
- Decode: is_md when dx_ir[31:27]==00000 and ALU op dx_ir[6:2] is 00110 (mul) or 00111 (div). rd = dx_ir[26:22].
- States: IDLE, BUSY, DONE. The state is encoded in 2 bits, and the unused encoding returns to IDLE.
- IDLE: stall=0. When is_md and !flush:
  - ctrl_mult or ctrl_div and stall are driven combinationally this cycle.
  - rd, op and the cycle counter (set to 0) are latched.
  - Next state is BUSY.
  - is_md with flush: no pulse, remain in IDLE.
- BUSY: stall=1, counter increments each cycle.
  - md_ready=1: latch md_result and md_exception, then go to DONE.
  - Timeout: counter reaches MAX_CYCLES-1 without md_ready. Force an exception, set timeout_err, then go to DONE.
  - flush=1 (takes priority over ready): go to IDLE, discard the op, no writeback.
- DONE: stall=0 so the pipeline advances at the end of this cycle. dx_bubble=1, wb_valid=1 (0 if flush this cycle). Next state is IDLE.
  - No exception: wb_rd=latched rd, wb_data=latched result.
  - Exception: wb_rd=30, wb_data=1 for mul or 2 for div. This is the rstatus convention.
- rd=0 is still sequenced and presented with wb_rd=0; the regfile ignores it.
- md_ready in IDLE or DONE is ignored. ctrl_mult and ctrl_div are never high together.
- When not in DONE, wb_rd and wb_data hold their last values. wb_valid is the only qualifier.

## Timing
- Reset (asynchronous, any state, mid-operation included): state=IDLE. Every output is 0 and timeout_err is 0. Reset does not drive the multdiv unit; the next pulse restarts it.
- Issue at cycle T with md_ready first high at T+k (k≥1):
  - stall is high in cycles T..T+k.
  - DONE, wb_valid and dx_bubble occur in cycle T+k+1.
  - Total stall is k+1 cycles.
- Timeout: DONE at T+MAX_CYCLES, with wb_rd=30.
- Back-to-back mul/div: the next op is seen in IDLE at T+k+2 at the earliest, because the new instruction reaches DX after DONE. The minimum issue-to-issue spacing is 3 cycles.
- No combinational path exists from md_* inputs to outputs. stall, ctrl_mult and ctrl_div in IDLE are combinational from dx_ir and flush.

## Test plan
- Reset low mid-BUSY (k=5, after 3 cycles) -> all outputs 0 immediately. After release, state is IDLE and no wb_valid occurs.
- mul r3 (rd=3) issued at T, md_ready at T+16 with result 0x0000002A -> ctrl_mult high only at T, stall high T..T+16, wb_valid at T+17 with wb_rd=3 and wb_data=0x2A, dx_bubble=1.
- div rd=7 with md_exception=1 at k=33 -> wb_valid at T+34 with wb_rd=30, wb_data=2; ctrl_div pulsed once.
- MAX_CYCLES=64, md_ready never asserted -> wb_valid at T+64 with wb_rd=30, wb_data=1 (mul); timeout_err=1 and stays high through subsequent ops.
- flush in BUSY at T+4 -> stall drops at T+5, no wb_valid. flush with is_md in IDLE -> no start pulse.
- Two consecutive muls, each with k=1 -> pulses at T and T+3, wb_valid at T+2 and T+5, no overlap.
